// File: rtl/csr_reg.sv
// Machine-mode CSR file: eight read/write CSRs, read-only cycle aliases,
// two write ports (write-back has priority) and a free-running 64-bit cycle counter.
module csr_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        clint_we_i,
  input  logic [31:0] clint_waddr_i,
  input  logic [31:0] clint_wdata_i,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic        global_int_en_o
);

  typedef enum logic [2:0] {
    CSR_MSTATUS,
    CSR_MIE,
    CSR_MTVEC,
    CSR_MSCRATCH,
    CSR_MEPC,
    CSR_MCAUSE,
    CSR_MCYCLE,
    CSR_MCYCLEH
  } csr_idx_e;

  typedef struct packed {
    logic     hit;
    csr_idx_e idx;
  } csr_sel_t;

  localparam int NUM_CSR = 8;

  // Write ports never match the cycle/cycleh aliases, so writes to them vanish.
  function automatic csr_sel_t decode(input logic [11:0] addr, input logic allow_alias);
    csr_sel_t sel;
    sel.hit = 1'b1;
    sel.idx = CSR_MSTATUS;
    case (addr)
      12'h300: sel.idx = CSR_MSTATUS;
      12'h304: sel.idx = CSR_MIE;
      12'h305: sel.idx = CSR_MTVEC;
      12'h340: sel.idx = CSR_MSCRATCH;
      12'h341: sel.idx = CSR_MEPC;
      12'h342: sel.idx = CSR_MCAUSE;
      12'hB00: sel.idx = CSR_MCYCLE;
      12'hB80: sel.idx = CSR_MCYCLEH;
      12'hC00: begin sel.idx = CSR_MCYCLE;  sel.hit = allow_alias; end
      12'hC80: begin sel.idx = CSR_MCYCLEH; sel.hit = allow_alias; end
      default: sel.hit = 1'b0;
    endcase
    return sel;
  endfunction

  logic [NUM_CSR-1:0][31:0] csr_q, csr_d;
  csr_sel_t wb_sel, clint_sel, rd_sel;
  logic     wb_hit, clint_hit;
  logic     wr_lo, wr_hi;
  logic [63:0] cycle_inc;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr_i[31:12], clint_waddr_i[31:12], raddr_i[31:12]};

  always_comb begin
    wb_sel    = decode(waddr_i[11:0], 1'b0);
    clint_sel = decode(clint_waddr_i[11:0], 1'b0);
    rd_sel    = decode(raddr_i[11:0], 1'b1);
    wb_hit    = we_i & wb_sel.hit;
    clint_hit = clint_we_i & clint_sel.hit & ~(wb_hit && (wb_sel.idx == clint_sel.idx));
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    csr_d     = csr_q;
    cycle_inc = {csr_q[CSR_MCYCLEH], csr_q[CSR_MCYCLE]} + 64'd1;
    wr_lo     = (wb_hit && wb_sel.idx == CSR_MCYCLE) || (clint_hit && clint_sel.idx == CSR_MCYCLE);
    wr_hi     = (wb_hit && wb_sel.idx == CSR_MCYCLEH) || (clint_hit && clint_sel.idx == CSR_MCYCLEH);

    if (clint_hit) csr_d[clint_sel.idx] = clint_wdata_i;
    if (wb_hit)    csr_d[wb_sel.idx]    = wdata_i;

    // A written counter word suppresses the carry into the high word.
    if (!wr_lo && !wr_hi) begin
      {csr_d[CSR_MCYCLEH], csr_d[CSR_MCYCLE]} = cycle_inc;
    end else if (!wr_lo) begin
      csr_d[CSR_MCYCLE] = cycle_inc[31:0];
    end
  end

  // NOTE: the whole register array is flop-based and is cleared by reset; it is not a RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      csr_q <= csr_d;
    end
  end

  always_comb begin
    rdata_o = 32'h0;
    if (rd_sel.hit) begin
      if (we_i && wb_sel.hit && wb_sel.idx == rd_sel.idx) begin
        rdata_o = wdata_i;
      end else if (clint_we_i && clint_sel.hit && clint_sel.idx == rd_sel.idx) begin
        rdata_o = clint_wdata_i;
      end else begin
        rdata_o = csr_q[rd_sel.idx];
      end
    end
  end

  assign mtvec_o         = csr_q[CSR_MTVEC];
  assign mepc_o          = csr_q[CSR_MEPC];
  assign mstatus_o       = csr_q[CSR_MSTATUS];
  assign global_int_en_o = csr_q[CSR_MSTATUS][3];

endmodule

// File: doc/csr_reg.md
CSR_REG -- requirements
Module: csr_reg

Interface
REQ-001 clk  in  1  core clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 we_i  in  1  CSR write enable from write-back stage.
REQ-004 waddr_i  in  32  CSR write address from write-back; only bits [11:0] decoded.
REQ-005 wdata_i  in  32  CSR write data from write-back.
REQ-006 clint_we_i  in  1  CSR write enable from interrupt controller.
REQ-007 clint_waddr_i  in  32  interrupt-controller write address; bits [11:0] decoded.
REQ-008 clint_wdata_i  in  32  interrupt-controller write data.
REQ-009 raddr_i  in  32  CSR read address from execute; bits [11:0] decoded.
REQ-010 rdata_o  out  32  CSR read data, combinational.
REQ-011 mtvec_o / mepc_o / mstatus_o  out  32 each  registered CSR values, no bypass.
REQ-012 global_int_en_o  out  1  equals registered mstatus[3].

Function
REQ-013 Mapped CSRs, all 32-bit read/write: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80.
REQ-014 Read-only aliases: cycle 0xC00 returns mcycle; cycleh 0xC80 returns mcycleh; writes to them are ignored.
REQ-015 Unmapped addresses read 0; writes to them are ignored with no side effect.
REQ-016 Writes take effect at the rising edge where the enable is 1; the value is visible on the dedicated outputs the next cycle.
REQ-017 Read bypass: if we_i=1 and waddr_i[11:0]==raddr_i[11:0] for a writable CSR, rdata_o = wdata_i in the same cycle.
REQ-018 Otherwise, if clint_we_i=1 and clint_waddr_i[11:0]==raddr_i[11:0] for a writable CSR, rdata_o = clint_wdata_i.
REQ-019 If neither bypass applies, rdata_o returns the registered value.
REQ-020 Writes from both ports in the same cycle to different CSRs both take effect.
REQ-021 Writes from both ports in the same cycle to the same CSR: the write-back port wins and the clint write is dropped.
REQ-022 {mcycleh,mcycle} forms a 64-bit counter that increments by 1 every cycle when not in reset.
REQ-023 Counter wraps from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-024 Write to mcycle: low word <= write data, high word holds; no carry is generated that cycle.
REQ-025 Write to mcycleh: high word <= write data, low word increments normally; any carry out of the low word that cycle is discarded.
REQ-026 Simultaneous writes to mcycle and mcycleh (one per port) both apply; the counter does not increment that cycle.
REQ-027 The cycle/cycleh aliases obey the bypass of REQ-017/018 when mcycle/mcycleh is being written.
REQ-028 Every state-holding element uses the single clock clk; there is no other clock domain.

Reset
REQ-029 While rst=0, all CSRs, including both counter words, SHALL be 0 regardless of clk.
REQ-030 Consequently rdata_o (non-bypassed) = 0, mtvec_o = mepc_o = mstatus_o = 0, and global_int_en_o = 0.
REQ-031 Reset asserted mid-operation clears state immediately (asynchronously); any write presented in that cycle is lost.
REQ-032 On the first rising edge after rst returns to 1, the counter increments 0 -> 1.

Verification
REQ-033 Reset release, then 5 idle cycles, read 0xC00 -> rdata_o = 5; read 0xC80 -> 0.
REQ-034 we_i=1, waddr 0x305, wdata 0x8000_0100, raddr 0x305 -> rdata_o = 0x8000_0100 in the same cycle; mtvec_o = 0x8000_0100 the next cycle.
REQ-035 Same cycle: we_i writes 0x341 = 0x11 and clint_we_i writes 0x341 = 0x22 -> mepc_o = 0x11 next cycle. Same cycle: clint writes 0x300 = 0x8 and wb writes 0x340 = 0x5 -> global_int_en_o = 1 and mscratch = 5.
REQ-036 Write mcycle = 0xFFFF_FFFF and mcycleh = 0xFFFF_FFFF in the same cycle; next cycle reads 0xFFFF_FFFF/0xFFFF_FFFF; the following cycle both read 0 (wrap).
REQ-037 Write 0xC00 = 0x1234, and write/read 0x7C0 -> counter unaffected, 0x7C0 reads 0, and no output changes.
REQ-038 Assert rst=0 asynchronously between clock edges with mstatus = 0x88 -> mstatus_o = 0 and global_int_en_o = 0 immediately, before the next clock edge.
